spi_sample_rx: RTL and testbench
================================

// Module: spi_sample_rx
// PURPOSE
//  SPI slave that receives the packed GPS I/Q sample stream sent by the bridge state machine.
//  It deserializes MCU_SCK/MCU_SS/MCU_MOSI back into 4-bit {I0,I1,Q0,Q1} samples and
//  buffers them in a FIFO with a valid/ready output.
//  Used as the loopback checker on the CPLD test build and as the MCU-side reference model.
//  The only clock is MCU_CLK_25_000. SPI pins are asynchronous to it and are oversampled.
// PARAMETERS
//  WORD_BITS   8   bits per SS-low word; multiple of 4, range 4..32
//  FIFO_DEPTH  8   sample FIFO entries; power of 2, range 2..32
// PORTS
//  MCU_CLK_25_000  in   1  sole clock; all logic on its rising edge
//  RESET_N         in   1  asynchronous, active-low reset
//  MCU_SCK         in   1  SPI clock from master, async; idles low
//  MCU_SS          in   1  SPI slave select from master, async, active low
//  MCU_MOSI        in   1  SPI data from master, async
//  SAMPLE_DATA     out  4  {I0,I1,Q0,Q1}, I0 = bit 3; valid only with SAMPLE_VALID
//  SAMPLE_VALID    out  1  FIFO not empty
//  SAMPLE_READY    in   1  consumer accepts; a pop occurs when VALID&READY
//  OVERFLOW        out  1  sticky: a sample was dropped because the FIFO was full
//  FRAME_ERR       out  1  sticky: SS rose with a partial word in the shifter
//  ERR_CLR         in   1  1-cycle pulse; clears OVERFLOW and FRAME_ERR
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, shifter and bit count 0, FSM in IDLE.
//  - Input sync: SCK, SS and MOSI each pass through a 2-FF synchronizer, then a history flop.
//    - SCK rise = sync 1 while history is 0; SS edges are detected the same way.
//    - Master must hold SCK high >=2 clocks and low >=2 clocks, and set up MOSI >=2 clocks
//      before the SCK rise.
//  - SPI mode 0: MOSI is sampled on the detected SCK rise, MSB first. SCK edges while SS=1
//    are ignored.
//  - FSM states:
//    - IDLE: waiting; shifter and count cleared. SS fall goes to SHIFT.
//    - SHIFT: each SCK rise does shift <= {shift[WORD_BITS-2:0],mosi} and count++.
//      - count reaching WORD_BITS latches the word into the unpack register, clears count,
//        and goes to UNPACK.
//      - SS rise with count != 0 sets FRAME_ERR, discards the partial word, and goes to IDLE.
//      - SS rise with count = 0 goes to IDLE with no error.
//    - UNPACK: writes WORD_BITS/4 nibbles to the FIFO, most significant nibble first, one
//      per clock.
//      - Returns to SHIFT (SS low) or IDLE (SS high); at least 4 clocks are left before the
//        next SCK rise can arrive.
//      - An SCK rise during UNPACK still shifts; the shifter and unpack register are separate.
//  - FIFO:
//    - Synchronous, circular pointers wrap at FIFO_DEPTH; an extra pointer bit gives the
//      full/empty distinction.
//    - Write to a full FIFO drops the nibble and sets OVERFLOW. A full FIFO with a
//      simultaneous pop accepts the write.
//    - Read-during-write on an empty FIFO: the data appears at the output the following cycle.
//  - Latency: from the detected SCK rise of the last bit, SAMPLE_VALID rises 2 clocks later
//    (latch, then first write). About 5 clocks from the pin edge.
//  - SAMPLE_DATA is the registered FIFO head. It holds while VALID=1 and READY=0.
//  - ERR_CLR in the same cycle as a new error event: the set wins and the flag stays 1.
//  - RESET_N asserted mid-word or mid-unpack: immediate clear, partial data lost, no flag set.
// CONFIGURATION
//  - SPI_RX_WORDCOUNT_EN defined:
//    - Adds output WORD_COUNT[15:0]: the count of complete words received.
//    - Increments on each UNPACK entry and wraps 0xFFFF -> 0. Reset and ERR_CLR set it to 0.
//  - Not defined: the port and counter are absent. All other behaviour is identical.
// TESTING
//  - Reset release, SS high, SCK toggling -> no FIFO writes; VALID=0, OVERFLOW=0, FRAME_ERR=0.
//  - One word 0xA5 (SCK half-period 4 clocks), READY=1 -> SAMPLE_DATA 0xA then 0x5,
//    one pulse each, no flags.
//  - Eight words 0x01..0x08 with READY=0, depth 8 -> VALID=1, OVERFLOW=1 after word 5.
//    Draining yields 0,1,0,2,0,3,0,4.
//  - SS rises after 5 bits of 0xFF -> FRAME_ERR=1, no FIFO write.
//    ERR_CLR pulse -> 0. Next word 0x3C -> 0x3, 0xC.
//  - RESET_N low after the 6th bit, then released, then word 0x96 -> only 0x9, 0x6 output.
//  - With SPI_RX_WORDCOUNT_EN: 300 words -> WORD_COUNT = 300. Forced start at 0xFFFF,
//    one word -> 0.

Source files
------------

// File: rtl/spi_sample_rx_if.sv
// Sample stream handshake between spi_sample_rx (master = producer) and its consumer.
interface spi_sample_rx_if;
    logic [3:0] SAMPLE_DATA;
    logic       SAMPLE_VALID;
    logic       SAMPLE_READY;

    modport master (output SAMPLE_DATA, output SAMPLE_VALID, input SAMPLE_READY);
    modport slave  (input SAMPLE_DATA, input SAMPLE_VALID, output SAMPLE_READY);
endinterface

// File: rtl/spi_sample_rx.sv
// SPI mode-0 slave that rebuilds packed {I0,I1,Q0,Q1} nibbles and buffers them in a FIFO.
// Optional feature macro SPI_RX_WORDCOUNT_EN adds the WORD_COUNT[15:0] output.
module spi_sample_rx #(
    parameter int WORD_BITS  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            MCU_CLK_25_000,
    input  logic            RESET_N,
    input  logic            MCU_SCK,
    input  logic            MCU_SS,
    input  logic            MCU_MOSI,
    spi_sample_rx_if.master smp,
    output logic            OVERFLOW,
    output logic            FRAME_ERR,
    input  logic            ERR_CLR
`ifdef SPI_RX_WORDCOUNT_EN
    ,
    output logic [15:0]     WORD_COUNT
`endif
);

    localparam int NIBS = WORD_BITS / 4;
    localparam int CW   = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int NW   = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UNPACK = 2'd2
    } state_t;

    logic sck_meta_r, sck_sync_r, sck_hist_r;
    logic ss_meta_r, ss_sync_r, ss_hist_r;
    logic mosi_meta_r, mosi_sync_r;
    logic sck_rise_s, ss_rise_s, ss_fall_s;

    state_t               state_r;
    logic [WORD_BITS-1:0] shift_r;
    logic [WORD_BITS-1:0] unpack_r;
    logic [CW-1:0]        bit_cnt_r;
    logic [NW-1:0]        nib_idx_r;

    logic                 shift_en_s;
    logic                 word_done_s;
    logic                 frame_set_s;
    logic                 wr_en_s;
    logic [3:0]           wr_nib_s;

    logic [3:0]           mem_r [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_r, rd_ptr_r, wr_ptr_n_s, rd_ptr_n_s;
    logic [3:0]           data_r, head_n_s;
    logic                 valid_r, valid_n_s;
    logic                 full_s, pop_s, push_s, drop_s;
    logic                 overflow_r, frame_err_r;

    // Two-stage synchronizers plus history flops for edge detection; SS idles high.
    always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
        if (!RESET_N) begin
            sck_meta_r  <= 1'b0;
            sck_sync_r  <= 1'b0;
            sck_hist_r  <= 1'b0;
            ss_meta_r   <= 1'b1;
            ss_sync_r   <= 1'b1;
            ss_hist_r   <= 1'b1;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
        end else begin
            sck_meta_r  <= MCU_SCK;
            sck_sync_r  <= sck_meta_r;
            sck_hist_r  <= sck_sync_r;
            ss_meta_r   <= MCU_SS;
            ss_sync_r   <= ss_meta_r;
            ss_hist_r   <= ss_sync_r;
            mosi_meta_r <= MCU_MOSI;
            mosi_sync_r <= mosi_meta_r;
        end
    end

    assign sck_rise_s = sck_sync_r & ~sck_hist_r;
    assign ss_rise_s  = ss_sync_r & ~ss_hist_r;
    assign ss_fall_s  = ~ss_sync_r & ss_hist_r;

    // Decode the shift, word-complete, framing-error and FIFO-write events for this cycle.
    always_comb begin
        shift_en_s  = 1'b0;
        word_done_s = 1'b0;
        frame_set_s = 1'b0;
        wr_en_s     = 1'b0;
        wr_nib_s    = unpack_r[(WORD_BITS-4) - 4*int'(nib_idx_r) +: 4];
        if ((state_r == ST_SHIFT) || (state_r == ST_UNPACK)) begin
            if (ss_rise_s) begin
                frame_set_s = (bit_cnt_r != '0);
            end else begin
                shift_en_s = sck_rise_s & ~ss_sync_r;
            end
        end else begin
            shift_en_s = 1'b0;
        end
        if (state_r == ST_SHIFT) begin
            word_done_s = shift_en_s && (bit_cnt_r == CW'(WORD_BITS - 1));
        end else begin
            word_done_s = 1'b0;
        end
        if (state_r == ST_UNPACK) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Receive FSM: shifter keeps running during UNPACK, which drains the latched word.
    always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r   <= ST_IDLE;
            shift_r   <= '0;
            unpack_r  <= '0;
            bit_cnt_r <= '0;
            nib_idx_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    shift_r   <= '0;
                    bit_cnt_r <= '0;
                    nib_idx_r <= '0;
                    if (ss_fall_s) begin
                        state_r <= ST_SHIFT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (ss_rise_s) begin
                        shift_r   <= '0;
                        bit_cnt_r <= '0;
                        state_r   <= ST_IDLE;
                    end else if (word_done_s) begin
                        shift_r   <= {shift_r[WORD_BITS-2:0], mosi_sync_r};
                        unpack_r  <= {shift_r[WORD_BITS-2:0], mosi_sync_r};
                        bit_cnt_r <= '0;
                        nib_idx_r <= '0;
                        state_r   <= ST_UNPACK;
                    end else if (shift_en_s) begin
                        shift_r   <= {shift_r[WORD_BITS-2:0], mosi_sync_r};
                        bit_cnt_r <= bit_cnt_r + CW'(1);
                    end else begin
                        state_r   <= ST_SHIFT;
                    end
                end
                ST_UNPACK: begin
                    if (ss_rise_s) begin
                        shift_r   <= '0;
                        bit_cnt_r <= '0;
                    end else if (shift_en_s) begin
                        shift_r   <= {shift_r[WORD_BITS-2:0], mosi_sync_r};
                        bit_cnt_r <= bit_cnt_r + CW'(1);
                    end else begin
                        shift_r   <= shift_r;
                    end
                    if (nib_idx_r == NW'(NIBS - 1)) begin
                        nib_idx_r <= '0;
                        // SS level decides the return state; catches an SS pulse hidden inside UNPACK.
                        state_r   <= ss_sync_r ? ST_IDLE : ST_SHIFT;
                    end else begin
                        nib_idx_r <= nib_idx_r + NW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign full_s = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s  = valid_r & smp.SAMPLE_READY;
    assign push_s = wr_en_s & (~full_s | pop_s);
    assign drop_s = wr_en_s & full_s & ~pop_s;

    // Next pointers and next registered head; a write landing on the new head is forwarded.
    always_comb begin
        wr_ptr_n_s = wr_ptr_r;
        rd_ptr_n_s = rd_ptr_r;
        if (push_s) begin
            wr_ptr_n_s = wr_ptr_r + (AW+1)'(1);
        end else begin
            wr_ptr_n_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_n_s = rd_ptr_r + (AW+1)'(1);
        end else begin
            rd_ptr_n_s = rd_ptr_r;
        end
        if (push_s && (wr_ptr_r[AW-1:0] == rd_ptr_n_s[AW-1:0])) begin
            head_n_s = wr_nib_s;
        end else begin
            head_n_s = mem_r[rd_ptr_n_s[AW-1:0]];
        end
        valid_n_s = (wr_ptr_n_s != rd_ptr_n_s);
    end

    // FIFO storage, pointers and the registered head/valid pair.
    always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 4'h0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            data_r   <= 4'h0;
            valid_r  <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= wr_nib_s;
            end
            wr_ptr_r <= wr_ptr_n_s;
            rd_ptr_r <= rd_ptr_n_s;
            data_r   <= head_n_s;
            valid_r  <= valid_n_s;
        end
    end

    // Sticky error flags; a new error in the same cycle as ERR_CLR keeps the flag set.
    always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
        if (!RESET_N) begin
            overflow_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            overflow_r  <= drop_s | (overflow_r & ~ERR_CLR);
            frame_err_r <= frame_set_s | (frame_err_r & ~ERR_CLR);
        end
    end

    assign smp.SAMPLE_DATA  = data_r;
    assign smp.SAMPLE_VALID = valid_r;
    assign OVERFLOW         = overflow_r;
    assign FRAME_ERR        = frame_err_r;

`ifdef SPI_RX_WORDCOUNT_EN
    logic [15:0] word_cnt_r;

    // Completed-word counter; a word finishing alongside ERR_CLR is counted after the clear.
    always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
        if (!RESET_N) begin
            word_cnt_r <= 16'h0000;
        end else if (ERR_CLR) begin
            word_cnt_r <= word_done_s ? 16'h0001 : 16'h0000;
        end else if (word_done_s) begin
            word_cnt_r <= word_cnt_r + 16'h0001;
        end else begin
            word_cnt_r <= word_cnt_r;
        end
    end

    assign WORD_COUNT = word_cnt_r;
`endif

endmodule

// File: tb/tb_spi_sample_rx.sv
// Directed bench for spi_sample_rx: reset, framing, latency, overflow and reset-mid-word.
`timescale 1ns/1ps
module tb_spi_sample_rx;
    localparam int HALF = 4;

    logic clk = 1'b0;
    logic rst_n, sck, ss, mosi, err_clr;
`ifdef SPI_RX_WORDCOUNT_EN
    logic [15:0] word_count;
`endif

    always #5 clk = ~clk;

    spi_sample_rx_if smp_if();

    spi_sample_rx #(.WORD_BITS(8), .FIFO_DEPTH(8)) dut (
        .MCU_CLK_25_000 (clk),
        .RESET_N        (rst_n),
        .MCU_SCK        (sck),
        .MCU_SS         (ss),
        .MCU_MOSI       (mosi),
        .smp            (smp_if),
        .OVERFLOW       (),
        .FRAME_ERR      (),
        .ERR_CLR        (err_clr)
`ifdef SPI_RX_WORDCOUNT_EN
        ,
        .WORD_COUNT     (word_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] rx_q[$];

    // Record every accepted sample away from the active edge.
    always @(negedge clk) begin
        if (smp_if.SAMPLE_VALID && smp_if.SAMPLE_READY) rx_q.push_back(smp_if.SAMPLE_DATA);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic sck_bit(input logic b);
        mosi = b;
        wait_clk(HALF);
        sck = 1'b1;
        wait_clk(HALF);
        sck = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        ss = 1'b0;
        wait_clk(HALF);
        for (int i = 7; i >= 0; i--) sck_bit(w[i]);
        wait_clk(HALF);
        ss = 1'b1;
        wait_clk(6);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ss = 1'b1; sck = 1'b0; mosi = 1'b0; err_clr = 1'b0;
        smp_if.SAMPLE_READY = 1'b1;
        wait_clk(3);
        n_tests++;
        if (smp_if.SAMPLE_VALID !== 1'b0 || smp_if.SAMPLE_DATA !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b data=%h, want valid=0 data=0", smp_if.SAMPLE_VALID, smp_if.SAMPLE_DATA);
        end
        rst_n = 1'b1;
        wait_clk(3);
        for (int i = 0; i < 10; i++) begin
            mosi = i[0];
            sck_bit(~i[1]);
        end
        wait_clk(6);
        n_tests++;
        if (smp_if.SAMPLE_VALID !== 1'b0 || rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_ss_high: valid=%b pops=%0d, want valid=0 pops=0", smp_if.SAMPLE_VALID, rx_q.size());
        end
        n_tests++;
        if (dut.OVERFLOW !== 1'b0 || dut.FRAME_ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: ovf=%b ferr=%b, want 0 0", dut.OVERFLOW, dut.FRAME_ERR);
        end
    endtask

    task automatic test_one_word;
        rx_q.delete();
        smp_if.SAMPLE_READY = 1'b1;
        send_word(8'hA5);
        wait_clk(4);
        n_tests++;
        if (rx_q.size() != 2) begin
            n_fail++;
            $display("FAIL one_word_count: got %0d samples, want 2", rx_q.size());
        end else begin
            n_tests++;
            if (rx_q[0] !== 4'hA || rx_q[1] !== 4'h5) begin
                n_fail++;
                $display("FAIL one_word_data: got %h %h, want a 5", rx_q[0], rx_q[1]);
            end
        end
        n_tests++;
        if (smp_if.SAMPLE_VALID !== 1'b0 || dut.OVERFLOW !== 1'b0 || dut.FRAME_ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL one_word_after: valid=%b ovf=%b ferr=%b, want 0 0 0", smp_if.SAMPLE_VALID, dut.OVERFLOW, dut.FRAME_ERR);
        end
    endtask

    task automatic test_latency;
        logic [7:0] w;
        w = 8'h5A;
        rx_q.delete();
        smp_if.SAMPLE_READY = 1'b0;
        ss = 1'b0;
        wait_clk(HALF);
        for (int i = 7; i >= 1; i--) sck_bit(w[i]);
        mosi = w[0];
        wait_clk(HALF);
        sck = 1'b1;
        wait_clk(3);
        n_tests++;
        if (smp_if.SAMPLE_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: valid=%b 3 clocks after pin rise, want 0", smp_if.SAMPLE_VALID);
        end
        wait_clk(1);
        n_tests++;
        if (smp_if.SAMPLE_VALID !== 1'b1 || smp_if.SAMPLE_DATA !== 4'h5) begin
            n_fail++;
            $display("FAIL latency_valid: valid=%b data=%h 4 clocks after pin rise, want 1 5", smp_if.SAMPLE_VALID, smp_if.SAMPLE_DATA);
        end
        sck = 1'b0;
        wait_clk(HALF);
        ss = 1'b1;
        wait_clk(6);
        n_tests++;
        if (smp_if.SAMPLE_DATA !== 4'h5 || rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL latency_hold: data=%h pops=%0d, want 5 0", smp_if.SAMPLE_DATA, rx_q.size());
        end
        smp_if.SAMPLE_READY = 1'b1;
        wait_clk(4);
        n_tests++;
        if (rx_q.size() != 2 || rx_q[0] !== 4'h5 || rx_q[1] !== 4'hA) begin
            n_fail++;
            $display("FAIL latency_drain: got %0d samples, want 5 a", rx_q.size());
        end
    endtask

    task automatic test_overflow;
        logic [3:0] exp_q [8];
        exp_q = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h3, 4'h0, 4'h4};
        rx_q.delete();
        smp_if.SAMPLE_READY = 1'b0;
        for (int w = 1; w <= 4; w++) send_word(8'(w));
        n_tests++;
        if (dut.OVERFLOW !== 1'b0 || smp_if.SAMPLE_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_word4: ovf=%b valid=%b, want 0 1", dut.OVERFLOW, smp_if.SAMPLE_VALID);
        end
        send_word(8'h05);
        n_tests++;
        if (dut.OVERFLOW !== 1'b1 || smp_if.SAMPLE_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_word5: ovf=%b valid=%b, want 1 1", dut.OVERFLOW, smp_if.SAMPLE_VALID);
        end
        for (int w = 6; w <= 8; w++) send_word(8'(w));
        smp_if.SAMPLE_READY = 1'b1;
        wait_clk(12);
        n_tests++;
        if (rx_q.size() != 8) begin
            n_fail++;
            $display("FAIL ovf_drain_count: got %0d samples, want 8", rx_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (rx_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL ovf_drain[%0d]: got %h, want %h", i, rx_q[i], exp_q[i]);
                end
            end
        end
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        wait_clk(1);
        n_tests++;
        if (dut.OVERFLOW !== 1'b0 || smp_if.SAMPLE_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: ovf=%b valid=%b, want 0 0", dut.OVERFLOW, smp_if.SAMPLE_VALID);
        end
    endtask

    task automatic test_frame_err;
        rx_q.delete();
        smp_if.SAMPLE_READY = 1'b1;
        ss = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 5; i++) sck_bit(1'b1);
        wait_clk(HALF);
        ss = 1'b1;
        wait_clk(2);
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        n_tests++;
        if (dut.FRAME_ERR !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_set_wins: ferr=%b with ERR_CLR on the error cycle, want 1", dut.FRAME_ERR);
        end
        wait_clk(4);
        n_tests++;
        if (smp_if.SAMPLE_VALID !== 1'b0 || rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL frame_no_write: valid=%b pops=%0d, want 0 0", smp_if.SAMPLE_VALID, rx_q.size());
        end
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        wait_clk(1);
        n_tests++;
        if (dut.FRAME_ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_clear: ferr=%b, want 0", dut.FRAME_ERR);
        end
        send_word(8'h3C);
        wait_clk(4);
        n_tests++;
        if (rx_q.size() != 2 || rx_q[0] !== 4'h3 || rx_q[1] !== 4'hC || dut.FRAME_ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_next_word: got %0d samples ferr=%b, want 3 c ferr=0", rx_q.size(), dut.FRAME_ERR);
        end
    endtask

    task automatic test_reset_mid;
        rx_q.delete();
        smp_if.SAMPLE_READY = 1'b1;
        ss = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 6; i++) sck_bit(1'b1);
        rst_n = 1'b0;
        ss = 1'b1;
        sck = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        send_word(8'h96);
        wait_clk(4);
        n_tests++;
        if (rx_q.size() != 2 || rx_q[0] !== 4'h9 || rx_q[1] !== 4'h6) begin
            n_fail++;
            $display("FAIL reset_mid_data: got %0d samples, want 9 6", rx_q.size());
        end
        n_tests++;
        if (dut.FRAME_ERR !== 1'b0 || dut.OVERFLOW !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_flags: ferr=%b ovf=%b, want 0 0", dut.FRAME_ERR, dut.OVERFLOW);
        end
    endtask

`ifdef SPI_RX_WORDCOUNT_EN
    task automatic test_word_count;
        smp_if.SAMPLE_READY = 1'b1;
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        n_tests++;
        if (word_count !== 16'd0) begin
            n_fail++;
            $display("FAIL wc_clear: got %0d, want 0", word_count);
        end
        for (int w = 0; w < 300; w++) send_word(8'(w));
        n_tests++;
        if (word_count !== 16'd300) begin
            n_fail++;
            $display("FAIL wc_300: got %0d, want 300", word_count);
        end
        rx_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_one_word();
        test_latency();
        test_overflow();
        test_frame_err();
        test_reset_mid();
`ifdef SPI_RX_WORDCOUNT_EN
        test_word_count();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
